// File: rtl/nibble_cmd_sequencer.sv
// nibble_cmd_sequencer
//   Command execution stage of the nibble CPU. Accepts one opcode + operand
//   through a valid/ready handshake and executes it against a DATA_W-bit
//   accumulator. Simple ALU ops take one EXEC cycle; MUL (shift-add) and
//   DIV (restoring) iterate for DATA_W EXEC cycles. Status is reported on the
//   cmd_start / cmd_busy / cmd_error / cmd_error_type interface.
//
// Ports
//   clk             clock, all state on rising edge
//   rst             asynchronous, active-high reset
//   cmd_valid       command request
//   cmd_ready       sequencer can accept (IDLE only)
//   cmd_opcode      0 NOP,1 LOAD,2 ADD,3 SUB,4 AND,5 OR,6 XOR,7 MUL,8 DIV,9-F illegal
//   cmd_operand     operand B
//   cmd_start       one-cycle pulse in the first execution cycle
//   cmd_busy        high from START through DONE
//   cmd_error       error flag, DONE cycle only
//   cmd_error_type  0 none,1 illegal,2 overflow,3 divide-by-zero; DONE cycle only
//   acc_out         accumulator
//   rem_out         remainder of the last successful DIV
module nibble_cmd_sequencer #(
  parameter int DATA_W  = 4,
  parameter int ACC_RST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [DATA_W-1:0] cmd_operand,
  output logic              cmd_start,
  output logic              cmd_busy,
  output logic              cmd_error,
  output logic [1:0]        cmd_error_type,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] rem_out
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] ACC_RST_V = ACC_RST[DATA_W-1:0];

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_DIV  = 4'd8;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ILL   = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_DIV0  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_EXEC, S_DONE} state_t;

  state_t state, state_nxt;

  logic [3:0]          op_q;
  logic [DATA_W-1:0]   opnd_q;
  logic [CNT_W-1:0]    cnt;
  // MUL: {partial product high, multiplier/low product}
  // DIV: {partial remainder, dividend/quotient}
  logic [2*DATA_W-1:0] work;
  // Simple-op result; bit DATA_W holds ADD carry / SUB borrow.
  logic [DATA_W:0]     res;
  logic [DATA_W-1:0]   acc, rem;

  logic                illegal, div0, iter_op;
  logic [1:0]          err_type;
  logic [DATA_W-1:0]   new_acc;

  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift, div_trial;

  // Single-cycle ALU; the extra top bit carries ADD overflow / SUB borrow.
  function automatic logic [DATA_W:0] alu(input logic [3:0] op,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    case (op)
      OP_LOAD: r = {1'b0, b};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  assign illegal = (op_q > OP_DIV);
  assign div0    = (op_q == OP_DIV) && (opnd_q == '0);
  assign iter_op = (op_q == OP_MUL) || (op_q == OP_DIV);

  // One shift-add multiply step: add multiplicand when multiplier LSB set, shift right.
  assign mul_sum = {1'b0, work[2*DATA_W-1:DATA_W]} + (work[0] ? {1'b0, acc} : '0);

  // One restoring divide step: bring in next dividend bit, try subtracting divisor.
  assign div_shift = {work[2*DATA_W-1:DATA_W], work[DATA_W-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  // Illegal opcode outranks any operand-dependent error.
  always_comb begin
    err_type = ERR_NONE;
    if (illegal)
      err_type = ERR_ILL;
    else if (div0)
      err_type = ERR_DIV0;
    else if ((op_q == OP_ADD || op_q == OP_SUB) && res[DATA_W])
      err_type = ERR_OVF;
    else if (op_q == OP_MUL && work[2*DATA_W-1:DATA_W] != '0)
      err_type = ERR_OVF;
  end

  always_comb begin
    new_acc = res[DATA_W-1:0];
    if (iter_op)
      new_acc = work[DATA_W-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt      = state;
    cmd_ready      = 1'b0;
    cmd_start      = 1'b0;
    cmd_busy       = 1'b0;
    cmd_error      = 1'b0;
    cmd_error_type = ERR_NONE;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_nxt = S_START;
      end
      S_START: begin
        cmd_start = 1'b1;
        cmd_busy  = 1'b1;
        state_nxt = (illegal || div0) ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        cmd_busy = 1'b1;
        if (!iter_op || cnt == '0)
          state_nxt = S_DONE;
      end
      S_DONE: begin
        cmd_busy       = 1'b1;
        cmd_error      = (err_type != ERR_NONE);
        cmd_error_type = err_type;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Architectural results commit at the end of DONE only when error-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= ACC_RST_V;
      rem <= '0;
    end else if (state == S_DONE && err_type == ERR_NONE) begin
      acc <= new_acc;
      if (op_q == OP_DIV)
        rem <= work[2*DATA_W-1:DATA_W];
    end
  end

  // Datapath working registers; no reset needed, each is loaded before use.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cmd_valid) begin
      op_q   <= cmd_opcode;
      opnd_q <= cmd_operand;
    end
    if (state == S_START) begin
      cnt <= CNT_W'(DATA_W - 1);
      if (op_q == OP_MUL)
        work <= {{DATA_W{1'b0}}, opnd_q};
      else
        work <= {{DATA_W{1'b0}}, acc};
    end
    if (state == S_EXEC) begin
      res <= alu(op_q, acc, opnd_q);
      if (cnt != '0)
        cnt <= cnt - CNT_W'(1);
      if (op_q == OP_MUL)
        work <= {mul_sum, work[DATA_W-1:1]};
      else if (op_q == OP_DIV) begin
        if (div_trial[DATA_W])
          work <= {div_shift[DATA_W-1:0], work[DATA_W-2:0], 1'b0};
        else
          work <= {div_trial[DATA_W-1:0], work[DATA_W-2:0], 1'b1};
      end
    end
  end

  assign acc_out = acc;
  assign rem_out = rem;

endmodule

// File: tb/tb_nibble_cmd_sequencer.sv
// Testbench for nibble_cmd_sequencer (DATA_W=4, ACC_RST=0): table of directed
// commands with hand-computed results, plus sequences for back-to-back
// acceptance and reset during a MUL.
module tb_nibble_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [3:0] cmd_operand;
  logic       cmd_start;
  logic       cmd_busy;
  logic       cmd_error;
  logic [1:0] cmd_error_type;
  logic [3:0] acc_out;
  logic [3:0] rem_out;

  int n_chk  = 0;
  int n_pass = 0;

  nibble_cmd_sequencer #(.DATA_W(4), .ACC_RST(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_opcode     (cmd_opcode),
    .cmd_operand    (cmd_operand),
    .cmd_start      (cmd_start),
    .cmd_busy       (cmd_busy),
    .cmd_error      (cmd_error),
    .cmd_error_type (cmd_error_type),
    .acc_out        (acc_out),
    .rem_out        (rem_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [3:0] opnd;
    logic [3:0] acc;
    logic [3:0] rem;
    logic       err;
    logic [1:0] et;
    int         cyc;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else
      n_pass++;
  endtask

  // Issue one command from an IDLE negedge; returns at the negedge of the
  // first IDLE cycle after the command.
  task automatic do_cmd(input logic [3:0] op, input logic [3:0] opnd,
                        output int cyc, output logic err, output logic [1:0] et,
                        output logic proto_ok, output logic timed_out);
    logic pending;
    cyc = 0; err = 1'b0; et = 2'd0; proto_ok = cmd_ready; timed_out = 1'b1;
    pending = 1'b0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_operand = opnd;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!cmd_busy) begin
        timed_out = 1'b0;
        break;
      end
      cyc++;
      if (cmd_start !== (cyc == 1)) proto_ok = 1'b0;
      if (cmd_ready !== 1'b0) proto_ok = 1'b0;
      if (pending) proto_ok = 1'b0;
      pending = cmd_error || (cmd_error_type != 2'd0);
      err = cmd_error;
      et  = cmd_error_type;
    end
    if (cmd_error !== 1'b0 || cmd_error_type !== 2'd0 || cmd_start !== 1'b0 || cmd_ready !== 1'b1)
      proto_ok = 1'b0;
  endtask

  initial begin
    int         cyc;
    logic       err, proto, to;
    logic [1:0] et;
    int         b;

    //              op     opnd   acc    rem    err   et    cyc
    vecs[0]  = '{4'h1, 4'd5,  4'd5,  4'd0, 1'b0, 2'd0, 3};
    vecs[1]  = '{4'h1, 4'd9,  4'd9,  4'd0, 1'b0, 2'd0, 3};
    vecs[2]  = '{4'h2, 4'd8,  4'd9,  4'd0, 1'b1, 2'd2, 3};
    vecs[3]  = '{4'h2, 4'd6,  4'd15, 4'd0, 1'b0, 2'd0, 3};
    vecs[4]  = '{4'h1, 4'd3,  4'd3,  4'd0, 1'b0, 2'd0, 3};
    vecs[5]  = '{4'h7, 4'd5,  4'd15, 4'd0, 1'b0, 2'd0, 6};
    vecs[6]  = '{4'h7, 4'd2,  4'd15, 4'd0, 1'b1, 2'd2, 6};
    vecs[7]  = '{4'h1, 4'd13, 4'd13, 4'd0, 1'b0, 2'd0, 3};
    vecs[8]  = '{4'h8, 4'd4,  4'd3,  4'd1, 1'b0, 2'd0, 6};
    vecs[9]  = '{4'h8, 4'd0,  4'd3,  4'd1, 1'b1, 2'd3, 2};
    vecs[10] = '{4'hC, 4'd2,  4'd3,  4'd1, 1'b1, 2'd1, 2};
    vecs[11] = '{4'h3, 4'd1,  4'd2,  4'd1, 1'b0, 2'd0, 3};
    vecs[12] = '{4'h3, 4'd5,  4'd2,  4'd1, 1'b1, 2'd2, 3};
    vecs[13] = '{4'h5, 4'd9,  4'd11, 4'd1, 1'b0, 2'd0, 3};
    vecs[14] = '{4'h6, 4'd6,  4'd13, 4'd1, 1'b0, 2'd0, 3};
    vecs[15] = '{4'h4, 4'd7,  4'd5,  4'd1, 1'b0, 2'd0, 3};
    vecs[16] = '{4'h0, 4'd9,  4'd5,  4'd1, 1'b0, 2'd0, 3};
    vecs[17] = '{4'h8, 4'd5,  4'd1,  4'd0, 1'b0, 2'd0, 6};
    vecs[18] = '{4'hF, 4'd0,  4'd1,  4'd0, 1'b1, 2'd1, 2};
    vecs[19] = '{4'h7, 4'd15, 4'd15, 4'd0, 1'b0, 2'd0, 6};
    vecs[20] = '{4'h7, 4'd0,  4'd0,  4'd0, 1'b0, 2'd0, 6};
    vecs[21] = '{4'h1, 4'd14, 4'd14, 4'd0, 1'b0, 2'd0, 3};
    vecs[22] = '{4'h8, 4'd3,  4'd4,  4'd2, 1'b0, 2'd0, 6};
    vecs[23] = '{4'h2, 4'd11, 4'd15, 4'd2, 1'b0, 2'd0, 3};
    vecs[24] = '{4'h3, 4'd15, 4'd0,  4'd2, 1'b0, 2'd0, 3};
    vecs[25] = '{4'h9, 4'd1,  4'd0,  4'd2, 1'b1, 2'd1, 2};
    vecs[26] = '{4'h1, 4'd6,  4'd6,  4'd2, 1'b0, 2'd0, 3};
    vecs[27] = '{4'h8, 4'd9,  4'd0,  4'd6, 1'b0, 2'd0, 6};

    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_operand = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_start", cmd_start, 0);
    chk("rst_busy",  cmd_busy, 0);
    chk("rst_err",   cmd_error, 0);
    chk("rst_etype", cmd_error_type, 0);
    chk("rst_acc",   acc_out, 0);
    chk("rst_rem",   rem_out, 0);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      do_cmd(vecs[i].op, vecs[i].opnd, cyc, err, et, proto, to);
      chk($sformatf("v%0d_timeout", i), to, 0);
      chk($sformatf("v%0d_busy_cycles", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      chk($sformatf("v%0d_etype", i), et, vecs[i].et);
      chk($sformatf("v%0d_proto", i), proto, 1);
      chk($sformatf("v%0d_acc", i), acc_out, vecs[i].acc);
      chk($sformatf("v%0d_rem", i), rem_out, vecs[i].rem);
    end

    // Back-to-back: valid held high is taken on the first IDLE cycle.
    cmd_valid = 1'b1; cmd_opcode = 4'h1; cmd_operand = 4'd7;
    @(posedge clk);
    #1 cmd_operand = 4'd4;
    b = 0;
    repeat (3) begin
      @(negedge clk);
      b += int'(cmd_busy);
    end
    chk("b2b_busy", b, 3);
    @(negedge clk);
    chk("b2b_idle_ready", cmd_ready, 1);
    chk("b2b_idle_acc", acc_out, 7);
    @(negedge clk);
    chk("b2b_second_start", cmd_start, 1);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_second_acc", acc_out, 4);
    chk("b2b_second_ready", cmd_ready, 1);

    // Reset in the middle of MUL EXEC.
    do_cmd(4'h1, 4'd3, cyc, err, et, proto, to);
    chk("pre_mul_acc", acc_out, 3);
    cmd_valid = 1'b1; cmd_opcode = 4'h7; cmd_operand = 4'd5;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mul_busy", cmd_busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_start", cmd_start, 0);
    chk("mid_rst_busy",  cmd_busy, 0);
    chk("mid_rst_err",   cmd_error, 0);
    chk("mid_rst_etype", cmd_error_type, 0);
    chk("mid_rst_acc",   acc_out, 0);
    chk("mid_rst_rem",   rem_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_cmd(4'h2, 4'd2, cyc, err, et, proto, to);
    chk("post_rst_timeout", to, 0);
    chk("post_rst_cycles", cyc, 3);
    chk("post_rst_err", err, 0);
    chk("post_rst_proto", proto, 1);
    chk("post_rst_acc", acc_out, 2);
    chk("post_rst_rem", rem_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
